// File: rtl/wb_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_buffer_pkg
// Brief    : Shared widths, entry type and sizing helper for the write buffer.
// Revision : 1.0  initial release
// ============================================================================
package wb_buffer_pkg;

   localparam int WB_DEPTH  = 4;
   localparam int WB_DATA_W = 16;
   localparam int WB_ADDR_W = 4;
   localparam int WB_CNT_W  = $clog2(WB_DEPTH) + 1;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_bypass_match.sv
`default_nettype none
// ============================================================================
// Module   : wb_bypass_match
// Brief    : Searches the pending-write queue for one register index and
//            returns the value of the youngest matching entry.
// Revision : 1.0  initial release
// ============================================================================
module wb_bypass_match
   import wb_buffer_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int PTR_W  = $clog2(WB_DEPTH)
)(
   input  logic [ADDR_W-1:0] i_ent_addr [DEPTH],
   input  logic [DATA_W-1:0] i_ent_data [DEPTH],
   input  logic [DEPTH-1:0]  i_valid,
   input  logic [PTR_W-1:0]  i_head,
   input  logic [ADDR_W-1:0] i_lookup,
   output logic              o_hit,
   output logic [DATA_W-1:0] o_data
);

   logic [PTR_W-1:0] w_idx;

   // Walk from oldest to newest so a later match overrides an earlier one.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_head + PTR_W'(k);
         if (i_valid[w_idx] && (i_ent_addr[w_idx] == i_lookup)) begin
            o_hit  = 1'b1;
            o_data = i_ent_data[w_idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_buffer
// Brief    : FIFO staging buffer in front of the register-file write port,
//            with rs/rt read bypass of not-yet-committed writes.
// Revision : 1.0  initial release
// ============================================================================
module wb_write_buffer
   import wb_buffer_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ADDR_W-1:0]             in_addr,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          wb_hold,
   output logic                          wb_en,
   output logic [ADDR_W-1:0]             wb_addr,
   output logic [DATA_W-1:0]             wb_data,
   input  logic [ADDR_W-1:0]             byp_rs_addr,
   output logic                          byp_rs_hit,
   output logic [DATA_W-1:0]             byp_rs_data,
   input  logic [ADDR_W-1:0]             byp_rt_addr,
   output logic                          byp_rt_hit,
   output logic [DATA_W-1:0]             byp_rt_data,
   output logic [cnt_width(DEPTH)-1:0]   count
);

   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam int                 c_CNT_W = cnt_width(DEPTH);
   localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

   logic [ADDR_W-1:0]  r_ent_addr [DEPTH];
   logic [DATA_W-1:0]  r_ent_data [DEPTH];
   logic [DEPTH-1:0]   r_valid;
   logic [c_PTR_W-1:0] r_head;
   logic [c_PTR_W-1:0] r_tail;
   logic [c_CNT_W-1:0] r_count;

   logic               w_nonempty;
   logic               w_push;
   logic               w_pop;
   logic [DEPTH-1:0]   w_valid_nxt;

   assign w_nonempty = (r_count != '0);
   // Readiness depends only on occupancy so a full buffer never refills in the
   // same cycle it drains, keeping wb_hold off the upstream handshake path.
   assign in_ready   = (r_count != c_FULL);
   assign w_push     = in_valid && in_ready;
   assign w_pop      = w_nonempty && !wb_hold;

   assign wb_en   = w_pop;
   assign wb_addr = w_nonempty ? r_ent_addr[r_head] : '0;
   assign wb_data = w_nonempty ? r_ent_data[r_head] : '0;
   assign count   = r_count;

   // Head and tail only coincide when empty or full, so pop and push never
   // touch the same valid bit in one cycle.
   always_comb begin
      w_valid_nxt = r_valid;
      if (w_pop) begin
         w_valid_nxt[r_head] = 1'b0;
      end
      if (w_push) begin
         w_valid_nxt[r_tail] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         if (w_pop) begin
            r_head <= r_head + c_PTR_W'(1);
         end
         if (w_push) begin
            r_tail <= r_tail + c_PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - c_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ent_addr[r_tail] <= in_addr;
         r_ent_data[r_tail] <= in_data;
      end
   end

   wb_bypass_match #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .PTR_W  (c_PTR_W)
   ) u_byp_rs (
      .i_ent_addr (r_ent_addr),
      .i_ent_data (r_ent_data),
      .i_valid    (r_valid),
      .i_head     (r_head),
      .i_lookup   (byp_rs_addr),
      .o_hit      (byp_rs_hit),
      .o_data     (byp_rs_data)
   );

   wb_bypass_match #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .PTR_W  (c_PTR_W)
   ) u_byp_rt (
      .i_ent_addr (r_ent_addr),
      .i_ent_data (r_ent_data),
      .i_valid    (r_valid),
      .i_head     (r_head),
      .i_lookup   (byp_rt_addr),
      .o_hit      (byp_rt_hit),
      .o_data     (byp_rt_data)
   );

endmodule
`default_nettype wire
